// File: rtl/tx_shifter.sv
// UART TX datapath: pops one FIFO byte per frame, drives the serial line and computes parity.
// Define TX_SHIFTER_TMR_EN to triplicate the state registers behind bitwise majority voters.
module tx_shifter #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned LSB_FIRST = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           State_i,
    input  logic [3:0]           BitCounter_i,
    input  logic                 p_BaudSig_i,
    input  logic [DATA_BITS-1:0] FifoData_i,
    input  logic                 ParityOdd_i,
    output logic                 p_FifoRd_o,
    output logic                 Tx_o,
    output logic                 ParityBit_o,
    output logic                 Busy_o,
    output logic                 p_ByteDone_o,
    output logic                 p_StateErr_o
);

    localparam logic [4:0] StInterval = 5'b00001;
    localparam logic [4:0] StStart    = 5'b00010;
    localparam logic [4:0] StData     = 5'b00100;
    localparam logic [4:0] StParity   = 5'b01000;
    localparam logic [4:0] StStop     = 5'b10000;

    // Voted (or single-copy) views of the protected registers
    logic [DATA_BITS-1:0] data_v;
    logic                 par_v;
    logic                 tx_v;
    logic [4:0]           prev_v;

    logic [DATA_BITS-1:0] data_d;
    logic                 par_d;
    logic                 tx_d;
    logic                 err_d;
    logic                 start_entry;
    logic [3:0]           bit_sel;
    logic [DATA_BITS-1:0] data_shift;

    logic fifo_rd_q;
    logic capture_q;
    logic done_q;
    logic err_q;

    assign start_entry = (State_i == StStart) && (prev_v != StStart);

    // FIFO data is valid the clk after the pop strobe, so capture one clk behind it
    assign data_d = capture_q ? FifoData_i : data_v;
    assign par_d  = capture_q ? ((^FifoData_i) ^ ParityOdd_i) : par_v;

    always_comb begin
        tx_d       = 1'b1;
        err_d      = 1'b0;
        bit_sel    = (LSB_FIRST != 0) ? BitCounter_i : (4'(DATA_BITS - 1) - BitCounter_i);
        data_shift = data_v >> bit_sel;
        case (State_i)
            StInterval: tx_d = 1'b1;
            StStart:    tx_d = 1'b0;
            StData: begin
                if ({28'd0, BitCounter_i} >= DATA_BITS) begin
                    err_d = 1'b1;
                end else begin
                    tx_d = data_shift[0];
                end
            end
            StParity:   tx_d = par_v;
            StStop:     tx_d = 1'b1;
            default:    err_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_rd_q <= 1'b0;
            capture_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            fifo_rd_q <= start_entry;
            capture_q <= fifo_rd_q;
            done_q    <= (State_i == StStop) && p_BaudSig_i;
            err_q     <= err_d;
        end
    end

`ifdef TX_SHIFTER_TMR_EN
    logic [DATA_BITS-1:0] data_a_q, data_b_q, data_c_q;
    logic                 par_a_q, par_b_q, par_c_q;
    logic                 tx_a_q, tx_b_q, tx_c_q;
    logic [4:0]           prev_a_q, prev_b_q, prev_c_q;

    // All copies rewritten every clk so a single upset is scrubbed on the next edge
    always_ff @(posedge clk) begin
        if (rst) begin
            data_a_q <= '0;
            data_b_q <= '0;
            data_c_q <= '0;
            par_a_q  <= 1'b0;
            par_b_q  <= 1'b0;
            par_c_q  <= 1'b0;
            tx_a_q   <= 1'b1;
            tx_b_q   <= 1'b1;
            tx_c_q   <= 1'b1;
            prev_a_q <= StInterval;
            prev_b_q <= StInterval;
            prev_c_q <= StInterval;
        end else begin
            data_a_q <= data_d;
            data_b_q <= data_d;
            data_c_q <= data_d;
            par_a_q  <= par_d;
            par_b_q  <= par_d;
            par_c_q  <= par_d;
            tx_a_q   <= tx_d;
            tx_b_q   <= tx_d;
            tx_c_q   <= tx_d;
            prev_a_q <= State_i;
            prev_b_q <= State_i;
            prev_c_q <= State_i;
        end
    end

    assign data_v = (data_a_q & data_b_q) | (data_a_q & data_c_q) | (data_b_q & data_c_q);
    assign par_v  = (par_a_q & par_b_q) | (par_a_q & par_c_q) | (par_b_q & par_c_q);
    assign tx_v   = (tx_a_q & tx_b_q) | (tx_a_q & tx_c_q) | (tx_b_q & tx_c_q);
    assign prev_v = (prev_a_q & prev_b_q) | (prev_a_q & prev_c_q) | (prev_b_q & prev_c_q);
`else
    logic [DATA_BITS-1:0] data_q;
    logic                 par_q;
    logic                 tx_q;
    logic [4:0]           prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            par_q  <= 1'b0;
            tx_q   <= 1'b1;
            prev_q <= StInterval;
        end else begin
            data_q <= data_d;
            par_q  <= par_d;
            tx_q   <= tx_d;
            prev_q <= State_i;
        end
    end

    assign data_v = data_q;
    assign par_v  = par_q;
    assign tx_v   = tx_q;
    assign prev_v = prev_q;
`endif

    assign p_FifoRd_o   = fifo_rd_q;
    assign Tx_o         = tx_v;
    assign ParityBit_o  = par_v;
    assign Busy_o       = (State_i != StInterval);
    assign p_ByteDone_o = done_q;
    assign p_StateErr_o = err_q;

endmodule

// File: tb/tb_tx_shifter.sv
// Scoreboard bench for tx_shifter: driver queues expected line/pulse values, monitor checks them.
// Runs an LSB-first and an MSB-first instance side by side on the same stimulus.
module tb_tx_shifter;

    localparam logic [4:0] StInt    = 5'b00001;
    localparam logic [4:0] StStart  = 5'b00010;
    localparam logic [4:0] StData   = 5'b00100;
    localparam logic [4:0] StParity = 5'b01000;
    localparam logic [4:0] StStop   = 5'b10000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] State_i = StInt;
    logic [3:0] BitCounter_i = 4'd0;
    logic       p_BaudSig_i = 1'b0;
    logic [7:0] FifoData_i = 8'h00;
    logic       ParityOdd_i = 1'b0;

    logic p_FifoRd_o, Tx_o, ParityBit_o, Busy_o, p_ByteDone_o, p_StateErr_o;
    logic m_FifoRd_o, m_Tx_o, m_ParityBit_o, m_Busy_o, m_ByteDone_o, m_StateErr_o;

    always #5 clk = ~clk;

    tx_shifter #(.DATA_BITS(8), .LSB_FIRST(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .State_i      (State_i),
        .BitCounter_i (BitCounter_i),
        .p_BaudSig_i  (p_BaudSig_i),
        .FifoData_i   (FifoData_i),
        .ParityOdd_i  (ParityOdd_i),
        .p_FifoRd_o   (p_FifoRd_o),
        .Tx_o         (Tx_o),
        .ParityBit_o  (ParityBit_o),
        .Busy_o       (Busy_o),
        .p_ByteDone_o (p_ByteDone_o),
        .p_StateErr_o (p_StateErr_o)
    );

    tx_shifter #(.DATA_BITS(8), .LSB_FIRST(0)) dut_msb (
        .clk          (clk),
        .rst          (rst),
        .State_i      (State_i),
        .BitCounter_i (BitCounter_i),
        .p_BaudSig_i  (p_BaudSig_i),
        .FifoData_i   (FifoData_i),
        .ParityOdd_i  (ParityOdd_i),
        .p_FifoRd_o   (m_FifoRd_o),
        .Tx_o         (m_Tx_o),
        .ParityBit_o  (m_ParityBit_o),
        .Busy_o       (m_Busy_o),
        .p_ByteDone_o (m_ByteDone_o),
        .p_StateErr_o (m_StateErr_o)
    );

    typedef struct packed {
        logic [15:0] id;
        logic        tx;
        logic        tx_msb;
        logic        err;
        logic        done;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   rd_cnt = 0;
    int   step_id = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Each queued entry describes the outputs after the next rising edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (p_FifoRd_o === 1'b1) rd_cnt++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk($sformatf("tx[%0d]", e.id), 32'(Tx_o), 32'(e.tx));
            chk($sformatf("tx_msb[%0d]", e.id), 32'(m_Tx_o), 32'(e.tx_msb));
            chk($sformatf("state_err[%0d]", e.id), 32'(p_StateErr_o), 32'(e.err));
            chk($sformatf("byte_done[%0d]", e.id), 32'(p_ByteDone_o), 32'(e.done));
        end
    end

    task automatic step(input logic r, input logic [4:0] st, input logic [3:0] cnt,
                        input logic baud, input logic etx, input logic emsb,
                        input logic eerr, input logic edone);
        exp_t e;
        @(negedge clk);
        rst          = r;
        State_i      = st;
        BitCounter_i = cnt;
        p_BaudSig_i  = baud;
        e.id     = 16'(step_id);
        e.tx     = etx;
        e.tx_msb = emsb;
        e.err    = eerr;
        e.done   = edone;
        exp_q.push_back(e);
        step_id++;
        #1;
        chk("busy", 32'(Busy_o), 32'(st != StInt));
    endtask

    // lsb/msb hold the expected wire bit for BitCounter_i = index
    task automatic frame(input logic [7:0] d, input logic po, input logic [7:0] lsb,
                         input logic [7:0] msb, input logic par, input logic upset);
        FifoData_i  = d;
        ParityOdd_i = po;
        step(1'b0, StInt, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (4) step(1'b0, StStart, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("parity_bit", 32'(ParityBit_o), 32'(par));
`ifdef TX_SHIFTER_TMR_EN
        if (upset) force dut.data_b_q = ~d;
`else
        if (upset) chk("upset_noop", 32'(ParityBit_o), 32'(par));
`endif
        for (int i = 0; i < 8; i++) begin
            step(1'b0, StData, 4'(i), 1'b0, lsb[i], msb[i], 1'b0, 1'b0);
        end
        step(1'b0, StParity, 4'd0, 1'b0, par, par, 1'b0, 1'b0);
`ifdef TX_SHIFTER_TMR_EN
        if (upset) release dut.data_b_q;
`endif
        step(1'b0, StStop, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, StStop, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset
        step(1'b1, StInt, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, StInt, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("rst_fifo_rd", 32'(p_FifoRd_o), 32'd0);
        chk("rst_parity", 32'(ParityBit_o), 32'd0);

        // 0xA5, even parity
        rd_cnt = 0;
        frame(8'hA5, 1'b0, 8'hA5, 8'hA5, 1'b0, 1'b0);
        step(1'b0, StInt, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("pops_a5", 32'(rd_cnt), 32'd1);

        // 0x01 odd then even parity
        rd_cnt = 0;
        frame(8'h01, 1'b1, 8'h01, 8'h80, 1'b0, 1'b0);
        frame(8'h01, 1'b0, 8'h01, 8'h80, 1'b1, 1'b0);
        step(1'b0, StInt, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("pops_01", 32'(rd_cnt), 32'd2);

        // Back-to-back: STOP+baud, INTERVAL, STARTBIT on consecutive clks
        rd_cnt = 0;
        frame(8'h55, 1'b0, 8'h55, 8'hAA, 1'b0, 1'b0);
        frame(8'hFF, 1'b0, 8'hFF, 8'hFF, 1'b0, 1'b0);
        step(1'b0, StInt, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("pops_b2b", 32'(rd_cnt), 32'd2);

        // Illegal state and index overrun
        rd_cnt = 0;
        repeat (3) step(1'b0, 5'b00110, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, StData, 4'd9, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 5'b00000, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, StInt, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("pops_illegal", 32'(rd_cnt), 32'd0);

        // Reset mid-DATABITS while the line is low
        FifoData_i  = 8'h01;
        ParityOdd_i = 1'b0;
        step(1'b0, StInt, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (4) step(1'b0, StStart, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("parity_pre_rst", 32'(ParityBit_o), 32'd1);
        step(1'b0, StData, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, StData, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, StData, 4'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        // Buffer cleared by reset, so bit 0 now reads 0
        step(1'b0, StData, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("parity_post_rst", 32'(ParityBit_o), 32'd0);
        step(1'b0, StInt, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        rd_cnt = 0;
        frame(8'hA5, 1'b0, 8'hA5, 8'hA5, 1'b0, 1'b1);
        step(1'b0, StInt, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("pops_after_rst", 32'(rd_cnt), 32'd1);

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
